uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Shares the single UART transmitter between up to four mode controllers: input echo, display, compute-result and error reporting. Each requester offers a byte stream framed by a `last` flag. The arbiter grants one requester at a time, round-robin, at message granularity, so multi-digit numbers and rows are never interleaved. It drives `tx_data`/`tx_start` and paces bytes on `tx_busy`.

## Interface
- `N_REQ`, default 3: number of requesters, legal range 1..4.
- `START_TIMEOUT`, default 16: cycles to wait for `tx_busy` to rise after a `tx_start` pulse.
- `STALL_TIMEOUT`, default 65535: cycles a granted requester may leave `req_valid` low mid-message before its grant is revoked.
- `clk`, in, 1: system clock; one clock domain.
- `rst`, in, 1: synchronous, active-high reset.
- `req_valid`, in, N_REQ: requester i has a byte on offer.
- `req_data`, in, 8*N_REQ: byte for requester i, at bits [8i+7:8i].
- `req_last`, in, N_REQ: the offered byte ends requester i's message.
- `req_ready`, out, N_REQ: one-cycle pulse; the byte is accepted, and the requester advances on this edge.
- `grant`, out, N_REQ: one-hot owner of the transmitter; all zero when idle.
- `tx_data`, out, 8: byte to the UART.
- `tx_start`, out, 1: one-cycle start pulse to the UART.
- `tx_busy`, in, 1: UART is shifting.
- `err_timeout`, out, 1: one-cycle pulse on a start timeout or stall timeout.

## Operation
- All outputs are registered. Reset values: `req_ready`=0, `grant`=0, `tx_data`=0, `tx_start`=0, `err_timeout`=0, state=IDLE, rr pointer=0, counters=0.
- **Round-robin select.** Scan `req_valid` starting at the pointer and wrapping modulo N_REQ; the first set bit wins (index w). The pointer becomes (w+1) mod N_REQ only when the message completes or is revoked.
- **IDLE.** Transition when `req_valid` is nonzero and `tx_busy`=0: set `grant`=onehot(w), go to SEND. Otherwise stay.
- **SEND.**
  - If `req_valid[w]`=1 and `tx_busy`=0: register `tx_data`=`req_data[w]`, `tx_start`=1, `req_ready[w]`=1, latch `last_q`=`req_last[w]`, clear the stall counter, go to WAIT_HI.
  - If `req_valid[w]`=0: increment the stall counter. When it reaches STALL_TIMEOUT, pulse `err_timeout`, clear `grant`, advance the pointer, go to IDLE.
- **WAIT_HI.** Go to WAIT_LO when `tx_busy`=1. If START_TIMEOUT cycles elapse first, pulse `err_timeout` and go to WAIT_LO anyway.
- **WAIT_LO.** Wait for `tx_busy`=0.
  - If `last_q`=1: clear `grant`, advance the pointer, go to IDLE.
  - Otherwise return to SEND with `grant` held.
- `tx_start` and `req_ready` are high for exactly one cycle per byte, on the same cycle.
- `req_data`/`req_last` of non-granted requesters are ignored. Their `req_ready` stays 0.
- Changes to `req_valid` of other requesters mid-message have no effect until IDLE.
- With N_REQ=1 the pointer stays at 0.

## Timing
- Accept latency: a request raised while IDLE with `tx_busy`=0 gets `grant` at edge +1 and `tx_start`/`req_ready` at edge +2.
- Byte spacing: the next byte is sampled in the SEND cycle after `tx_busy` falls. That gives a minimum of 2 cycles from the `tx_busy` fall to the next `tx_start`, with no gap byte.
- Message switch: last byte completes in WAIT_LO, then IDLE, then SEND. The new `tx_start` comes ≥3 cycles after the `tx_busy` fall.
- Simultaneous requests in IDLE: the pointer decides, with no fixed priority.
- `tx_busy` already high in IDLE, for example a byte left over from before reset: no grant is issued until it falls.
- Reset mid-message: all outputs clear on the next edge. A byte already in the UART finishes without being tracked. The requester sees no `req_ready` and must resend.
- Stall counter is 16 bits and saturates. The start-timeout counter is 5 bits or wider, as needed for START_TIMEOUT.

## Test plan
- **Single byte.** Req 1 offers 0x41 with last=1; UART model busy 10 cycles starting 1 cycle after start. Expect `grant`=3'b010, one `tx_start` with `tx_data`=0x41, one `req_ready[1]` pulse, then `grant`=0, pointer=2.
- **Contention and atomicity.** Req 0 sends "128 " (4 bytes, last on the space) while req 2 requests continuously. Expect all 4 bytes of req 0 contiguous, then req 2 granted, with no interleaving.
- **Fairness.** All three requesters stream 1-byte messages continuously. Expect grant order 0,1,2,0,1,2 over 6 messages.
- **Start timeout.** UART model never raises `tx_busy`. Expect an `err_timeout` pulse 16 cycles after `tx_start`, after which the next byte is sent.
- **Stall revoke.** Req 1 sends a non-last byte, then drops `req_valid`; STALL_TIMEOUT=20. Expect `err_timeout` at cycle 20, `grant` cleared, and pending req 2 granted next.
- **Reset mid-message.** Assert `rst` during WAIT_LO. Expect every output 0 on the next edge and the pointer at 0. After release, req 0 is granted first when all three requesters request.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-atomic arbiter sharing one UART transmitter between up to
// four byte-stream requesters; paces bytes on tx_busy and flags start/stall timeouts.
module uart_tx_arbiter #(
  parameter int N_REQ         = 3,
  parameter int START_TIMEOUT = 16,
  parameter int STALL_TIMEOUT = 65535
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic [N_REQ-1:0]   grant,
  output logic [7:0]         tx_data,
  output logic               tx_start,
  input  logic               tx_busy,
  output logic               err_timeout
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int SW = ($clog2(START_TIMEOUT + 1) > 5) ? $clog2(START_TIMEOUT + 1) : 5;
  localparam logic [SW-1:0] START_LIM = SW'(START_TIMEOUT);
  localparam logic [15:0]   STALL_LIM = (STALL_TIMEOUT > 65535) ? 16'hFFFF : 16'(STALL_TIMEOUT);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_HI, WAIT_LO} state_t;

  state_t           state, state_n;
  logic [PW-1:0]    ptr, ptr_n, owner, owner_n, win, ptr_adv;
  logic             last_q, last_n;
  logic [15:0]      stall_cnt, stall_n, stall_inc;
  logic [SW-1:0]    start_cnt, start_n, start_inc;
  logic [N_REQ-1:0] grant_n, ready_n;
  logic [7:0]       data_n, sel_data;
  logic             start_pulse_n, err_n, sel_valid, sel_last;

  function automatic logic [PW-1:0] wrap_idx(input logic [PW:0] sum);
    logic [PW:0] r;
    r = (sum >= (PW+1)'(N_REQ)) ? sum - (PW+1)'(N_REQ) : sum;
    return r[PW-1:0];
  endfunction

  // First valid requester at or after the pointer, wrapping modulo N_REQ.
  function automatic logic [PW-1:0] rr_pick(input logic [N_REQ-1:0] valid,
                                            input logic [PW-1:0]    base);
    logic [PW-1:0] pick, idx;
    logic          found;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = wrap_idx({1'b0, base} + (PW+1)'(k));
      if (!found && valid[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
    return pick;
  endfunction

  assign win     = rr_pick(req_valid, ptr);
  assign ptr_adv = wrap_idx({1'b0, owner} + (PW+1)'(1));

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = 8'h00;
    for (int k = 0; k < N_REQ; k++) begin
      if (owner == PW'(k)) begin
        sel_valid = req_valid[k];
        sel_last  = req_last[k];
        sel_data  = req_data[8*k +: 8];
      end
    end
  end

  always_comb begin
    state_n       = state;
    ptr_n         = ptr;
    owner_n       = owner;
    last_n        = last_q;
    stall_n       = stall_cnt;
    start_n       = start_cnt;
    grant_n       = grant;
    ready_n       = '0;
    data_n        = tx_data;
    start_pulse_n = 1'b0;
    err_n         = 1'b0;
    stall_inc     = (stall_cnt == 16'hFFFF) ? stall_cnt : stall_cnt + 16'd1;
    start_inc     = (&start_cnt) ? start_cnt : start_cnt + SW'(1);
    case (state)
      IDLE: begin
        if (|req_valid && !tx_busy) begin
          owner_n      = win;
          grant_n      = '0;
          grant_n[win] = 1'b1;
          stall_n      = '0;
          state_n      = SEND;
        end
      end
      SEND: begin
        if (sel_valid && !tx_busy) begin
          data_n         = sel_data;
          start_pulse_n  = 1'b1;
          ready_n[owner] = 1'b1;
          last_n         = sel_last;
          stall_n        = '0;
          start_n        = '0;
          state_n        = WAIT_HI;
        end else if (!sel_valid) begin
          stall_n = stall_inc;
          // Owner went quiet mid-message: revoke so the others are not starved.
          if (stall_inc >= STALL_LIM) begin
            err_n   = 1'b1;
            grant_n = '0;
            ptr_n   = ptr_adv;
            stall_n = '0;
            state_n = IDLE;
          end
        end
      end
      WAIT_HI: begin
        if (tx_busy) begin
          state_n = WAIT_LO;
        end else begin
          start_n = start_inc;
          if (start_inc >= START_LIM) begin
            err_n   = 1'b1;
            state_n = WAIT_LO;
          end
        end
      end
      WAIT_LO: begin
        if (!tx_busy) begin
          if (last_q) begin
            grant_n = '0;
            ptr_n   = ptr_adv;
            state_n = IDLE;
          end else begin
            state_n = SEND;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      owner       <= '0;
      last_q      <= 1'b0;
      stall_cnt   <= '0;
      start_cnt   <= '0;
      grant       <= '0;
      req_ready   <= '0;
      tx_data     <= 8'h00;
      tx_start    <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_n;
      ptr         <= ptr_n;
      owner       <= owner_n;
      last_q      <= last_n;
      stall_cnt   <= stall_n;
      start_cnt   <= start_n;
      grant       <= grant_n;
      req_ready   <= ready_n;
      tx_data     <= data_n;
      tx_start    <= start_pulse_n;
      err_timeout <= err_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: queue-driven requesters, a UART busy model
// and a message-level round-robin reference model.
module tb_uart_tx_arbiter;

  localparam int N        = 3;
  localparam int START_TO = 16;
  localparam int STALL_TO = 20;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid, req_last, req_ready, grant;
  logic [8*N-1:0] req_data;
  logic [7:0]     tx_data;
  logic           tx_start, tx_busy, err_timeout;

  int tests_run    = 0;
  int tests_failed = 0;
  int cycle        = 0;

  logic [8:0]   drv_q   [N][$];
  logic [8:0]   stage_q [N][$];
  logic [8:0]   mdl_q   [N][$];
  logic [9:0]   exp_q[$], obs_q[$];
  int           start_cyc[$], err_cyc[$], fall_cyc[$];
  logic [N-1:0] err_grant[$];
  int           ready_cnt [N];
  int           model_ptr = 0;

  bit uart_en   = 1'b1;
  int uart_dmin = 0, uart_dmax = 2, uart_lmin = 1, uart_lmax = 6;

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  uart_tx_arbiter #(.N_REQ(N), .START_TIMEOUT(START_TO), .STALL_TIMEOUT(STALL_TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .grant(grant), .tx_data(tx_data), .tx_start(tx_start),
    .tx_busy(tx_busy), .err_timeout(err_timeout)
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] onehot_idx(input logic [N-1:0] g);
    logic [1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) if (g[i]) r = 2'(i);
    return r;
  endfunction

  // Requesters: offer the queue head, advance on the cycle req_ready is seen.
  initial begin
    logic [8:0] head;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (req_ready[i] && drv_q[i].size() > 0) void'(drv_q[i].pop_front());
        if (drv_q[i].size() > 0) begin
          head               = drv_q[i][0];
          req_valid[i]       = 1'b1;
          req_data[8*i +: 8] = head[7:0];
          req_last[i]        = head[8];
        end else begin
          req_valid[i]       = 1'b0;
          req_data[8*i +: 8] = 8'h00;
          req_last[i]        = 1'b0;
        end
      end
    end
  end

  // UART: busy for a random length after a random delay following each start.
  initial begin
    int d, l;
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start && uart_en) begin
        d = $urandom_range(uart_dmax, uart_dmin);
        l = $urandom_range(uart_lmax, uart_lmin);
        repeat (d) @(negedge clk);
        tx_busy = 1'b1;
        repeat (l) @(negedge clk);
        tx_busy = 1'b0;
        fall_cyc.push_back(cycle);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        check_output("ready_vs_start", req_ready, tx_start ? grant : '0);
        check_output("grant_onehot", $countones(grant) <= 1, 1);
        if (tx_start) begin
          obs_q.push_back({onehot_idx(grant), tx_data});
          start_cyc.push_back(cycle);
        end
        if (err_timeout) begin
          err_cyc.push_back(cycle);
          err_grant.push_back(grant);
        end
        for (int i = 0; i < N; i++) if (req_ready[i]) ready_cnt[i]++;
      end
    end
  end

  task automatic push_byte(input int r, input logic [7:0] d, input bit last, input bit modeled);
    stage_q[r].push_back({last, d});
    if (modeled) mdl_q[r].push_back({last, d});
  endtask

  // Reference: whole messages in pointer order; a message without a last byte is
  // abandoned when its bytes run out, and the pointer moves past its owner.
  task automatic model_run();
    int w;
    logic [8:0] b;
    bit more;
    forever begin
      w = -1;
      for (int k = 0; k < N; k++)
        if (w < 0 && mdl_q[(model_ptr + k) % N].size() > 0) w = (model_ptr + k) % N;
      if (w < 0) break;
      more = 1'b1;
      while (more) begin
        b = mdl_q[w].pop_front();
        exp_q.push_back({2'(w), b[7:0]});
        more = !b[8] && mdl_q[w].size() > 0;
      end
      model_ptr = (w + 1) % N;
    end
  endtask

  task automatic apply_stimulus();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      while (stage_q[i].size() > 0) drv_q[i].push_back(stage_q[i].pop_front());
    model_run();
  endtask

  task automatic wait_idle(input int budget);
    bit done;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge clk);
      done = drv_q[0].size() == 0 && drv_q[1].size() == 0 && drv_q[2].size() == 0 &&
             grant == '0 && !tx_busy && !tx_start;
    end
    check_output("idle_reached", done, 1);
  endtask

  task automatic compare_stream(input string tag);
    check_output({tag, "_len"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check_output($sformatf("%s_byte%0d", tag, i), obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic clear_events();
    start_cyc.delete();
    err_cyc.delete();
    err_grant.delete();
    fall_cyc.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_grant"}, grant, 0);
    check_output({tag, "_ready"}, req_ready, 0);
    check_output({tag, "_data"}, tx_data, 0);
    check_output({tag, "_start"}, tx_start, 0);
    check_output({tag, "_err"}, err_timeout, 0);
  endtask

  initial begin
    int nm, len;
    bit reached;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single byte with exact accept latency.
    uart_dmin = 1; uart_dmax = 1; uart_lmin = 10; uart_lmax = 10;
    clear_events();
    push_byte(1, 8'h41, 1'b1, 1'b1);
    apply_stimulus();
    @(negedge clk);
    @(negedge clk);
    check_output("single_grant", grant, 3'b010);
    check_output("single_no_start_yet", tx_start, 0);
    @(negedge clk);
    check_output("single_start", tx_start, 1);
    check_output("single_data", tx_data, 8'h41);
    check_output("single_ready", req_ready, 3'b010);
    wait_idle(200);
    compare_stream("single");
    check_output("single_ready_cnt", ready_cnt[1], 1);
    check_output("single_no_err", err_cyc.size(), 0);

    // Contention: req0 "128 " against req2 requesting continuously.
    uart_dmin = 0; uart_dmax = 2; uart_lmin = 1; uart_lmax = 6;
    clear_events();
    push_byte(0, "1", 1'b0, 1'b1);
    push_byte(0, "2", 1'b0, 1'b1);
    push_byte(0, "8", 1'b0, 1'b1);
    push_byte(0, " ", 1'b1, 1'b1);
    push_byte(2, "A", 1'b1, 1'b1);
    push_byte(2, "B", 1'b0, 1'b1);
    push_byte(2, "C", 1'b1, 1'b1);
    apply_stimulus();
    wait_idle(600);
    compare_stream("contend");
    check_output("contend_no_err", err_cyc.size(), 0);

    // Fairness: every requester streams one-byte messages.
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < N; i++) push_byte(i, 8'(8'h30 + 8'(m * N + i)), 1'b1, 1'b1);
    apply_stimulus();
    wait_idle(600);
    compare_stream("fair");

    // Start timeout: the UART never raises tx_busy.
    uart_en = 1'b0;
    clear_events();
    push_byte(0, 8'h10, 1'b0, 1'b1);
    push_byte(0, 8'h11, 1'b1, 1'b1);
    apply_stimulus();
    wait_idle(300);
    compare_stream("start_to");
    check_output("start_to_err_cnt", err_cyc.size(), 2);
    if (err_cyc.size() > 0 && start_cyc.size() > 1) begin
      check_output("start_to_err_delay", err_cyc[0] - start_cyc[0], START_TO);
      check_output("start_to_next_byte", start_cyc[1] - start_cyc[0], START_TO + 2);
      check_output("start_to_grant_held", err_grant[0], 3'b001);
    end
    uart_en = 1'b1;
    repeat (2) @(negedge clk);

    // Reset while the owner waits for its byte to finish shifting.
    uart_dmin = 0; uart_dmax = 0; uart_lmin = 12; uart_lmax = 12;
    clear_events();
    push_byte(1, 8'h61, 1'b0, 1'b0);
    push_byte(1, 8'h62, 1'b0, 1'b0);
    push_byte(1, 8'h63, 1'b1, 1'b0);
    apply_stimulus();
    reached = 1'b0;
    for (int c = 0; c < 100 && !reached; c++) begin
      @(negedge clk);
      reached = tx_busy && grant != '0;
    end
    check_output("rst_reached_wait_lo", reached, 1);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < N; i++) drv_q[i].delete();
    model_ptr = 0;
    @(negedge clk);
    check_reset_outputs("rst_mid");
    rst = 1'b0;
    obs_q.delete();
    for (int i = 0; i < N; i++) push_byte(i, 8'(8'h70 + 8'(i)), 1'b1, 1'b1);
    apply_stimulus();
    for (int c = 0; c < 30 && tx_busy; c++) begin
      @(negedge clk);
      if (tx_busy) check_output("no_grant_while_busy", grant, 0);
    end
    uart_lmin = 1; uart_lmax = 6;
    wait_idle(400);
    compare_stream("rst_after");

    // Stall: req1 sends a non-last byte then goes quiet; req2 waits.
    uart_dmin = 1; uart_dmax = 1; uart_lmin = 4; uart_lmax = 4;
    clear_events();
    push_byte(1, 8'h55, 1'b0, 1'b1);
    push_byte(2, 8'h77, 1'b1, 1'b1);
    apply_stimulus();
    wait_idle(400);
    compare_stream("stall");
    check_output("stall_err_cnt", err_cyc.size(), 1);
    if (err_cyc.size() > 0 && fall_cyc.size() > 0) begin
      check_output("stall_err_delay", err_cyc[0] - fall_cyc[0], STALL_TO + 1);
      check_output("stall_grant_cleared", err_grant[0], 0);
    end

    // Randomized message mixes.
    uart_dmin = 0; uart_dmax = 3; uart_lmin = 1; uart_lmax = 8;
    for (int r = 0; r < 4; r++) begin
      clear_events();
      for (int i = 0; i < N; i++) begin
        nm = $urandom_range(2, 0);
        for (int m = 0; m < nm; m++) begin
          len = $urandom_range(4, 1);
          for (int b = 0; b < len; b++) push_byte(i, 8'($urandom), b == len - 1, 1'b1);
        end
      end
      apply_stimulus();
      wait_idle(3000);
      compare_stream($sformatf("rand%0d", r));
      check_output($sformatf("rand%0d_no_err", r), err_cyc.size(), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
